// File: rtl/lcd_nibble_writer_if.sv
// Request/response handshake plus the 4-bit HD44780 pin bundle of the LCD nibble writer.
interface lcd_nibble_writer_if;
  logic       start;
  logic [7:0] data;
  logic       rs;
  logic       nibble_only;
  logic       ready;
  logic       done;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_data;

  modport master (
    output start, data, rs, nibble_only,
    input  ready, done, lcd_e, lcd_rs, lcd_rw, lcd_data
  );

  modport slave (
    input  start, data, rs, nibble_only,
    output ready, done, lcd_e, lcd_rs, lcd_rw, lcd_data
  );
endinterface

// File: rtl/lcd_nibble_writer.sv
// Sends one LCD byte (or a single init nibble) over the 4-bit HD44780 bus, owning setup,
// enable-pulse, hold, inter-nibble gap and post-write wait timing.
module lcd_nibble_writer #(
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned PULSE_CYCLES      = 12,
  parameter int unsigned HOLD_CYCLES       = 1,
  parameter int unsigned NIBBLE_GAP_CYCLES = 50,
  parameter int unsigned BYTE_WAIT_CYCLES  = 2000,
  parameter int unsigned LONG_WAIT_CYCLES  = 82000
) (
  input logic             clk,
  input logic             rst,
  lcd_nibble_writer_if.slave bus
);

  localparam int unsigned CntW   = 20;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > CntMax ||
      PULSE_CYCLES < 1 || PULSE_CYCLES > CntMax ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > CntMax ||
      NIBBLE_GAP_CYCLES < 1 || NIBBLE_GAP_CYCLES > CntMax ||
      BYTE_WAIT_CYCLES < 1 || BYTE_WAIT_CYCLES > CntMax ||
      LONG_WAIT_CYCLES < 1 || LONG_WAIT_CYCLES > CntMax) begin : g_param_check
    $error("lcd_nibble_writer: every cycle parameter must be in 1..2^20-1");
  end

  // The start edge itself counts as one extra upper-nibble setup cycle.
  localparam logic [CntW-1:0] SetupFirstLd = CntW'(SETUP_CYCLES);
  localparam logic [CntW-1:0] SetupLd      = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] PulseLd      = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLd       = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLd        = CntW'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [CntW-1:0] ByteLd       = CntW'(BYTE_WAIT_CYCLES - 1);
  localparam logic [CntW-1:0] LongLd       = CntW'(LONG_WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StSetupHi, StPulseHi, StHoldHi, StGap, StSetupLo, StPulseLo, StHoldLo, StWait
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      byte_q;
  logic            rs_q;
  logic            nib_q;
  logic            ready_q;
  logic            done_q;
  logic            e_q;
  logic            lcd_rs_q;
  logic [3:0]      lcd_data_q;

  logic            long_wait;
  logic [CntW-1:0] wait_ld;
  logic            cnt_zero;

  // Clear Display (0x01) and Return Home (0x02/0x03) need the long busy time.
  always_comb begin
    long_wait = !rs_q && !nib_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
    wait_ld   = long_wait ? LongLd : ByteLd;
  end

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      byte_q     <= '0;
      rs_q       <= 1'b0;
      nib_q      <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      e_q        <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!cnt_zero) begin
        cnt_q <= cnt_q - CntW'(1);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              byte_q     <= bus.data;
              rs_q       <= bus.rs;
              nib_q      <= bus.nibble_only;
              lcd_rs_q   <= bus.rs;
              lcd_data_q <= bus.data[7:4];
              ready_q    <= 1'b0;
              cnt_q      <= SetupFirstLd;
              state_q    <= StSetupHi;
            end
          end
          StSetupHi: begin
            e_q     <= 1'b1;
            cnt_q   <= PulseLd;
            state_q <= StPulseHi;
          end
          StPulseHi: begin
            e_q     <= 1'b0;
            cnt_q   <= HoldLd;
            state_q <= StHoldHi;
          end
          StHoldHi: begin
            if (nib_q) begin
              lcd_rs_q   <= 1'b0;
              lcd_data_q <= '0;
              cnt_q      <= wait_ld;
              state_q    <= StWait;
            end else begin
              cnt_q   <= GapLd;
              state_q <= StGap;
            end
          end
          StGap: begin
            lcd_data_q <= byte_q[3:0];
            cnt_q      <= SetupLd;
            state_q    <= StSetupLo;
          end
          StSetupLo: begin
            e_q     <= 1'b1;
            cnt_q   <= PulseLd;
            state_q <= StPulseLo;
          end
          StPulseLo: begin
            e_q     <= 1'b0;
            cnt_q   <= HoldLd;
            state_q <= StHoldLo;
          end
          StHoldLo: begin
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
            cnt_q      <= wait_ld;
            state_q    <= StWait;
          end
          StWait: begin
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.lcd_e    = e_q;
  assign bus.lcd_rs   = lcd_rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_data = lcd_data_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Self-checking bench for lcd_nibble_writer: vector table, random transfers against a timing
// model, plus reset and back-to-back sequences.
module tb_lcd_nibble_writer;

  // Default strobe timing; waits shortened to keep the run small.
  localparam int SetupC = 2;
  localparam int PulseC = 12;
  localparam int HoldC  = 1;
  localparam int GapC   = 50;
  localparam int ByteC  = 300;
  localparam int LongC  = 1500;

  localparam int FirstOff  = SetupC + 1;
  localparam int SecondOff = FirstOff + PulseC + HoldC + GapC + SetupC;
  localparam int NibN      = SetupC + 1 + PulseC + HoldC + ByteC;
  localparam int FullN     = SetupC + 1 + 2 * (PulseC + HoldC) + GapC + SetupC + ByteC;
  localparam int LongN     = FullN - ByteC + LongC;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_nibble_writer_if bus ();

  lcd_nibble_writer #(
    .SETUP_CYCLES     (SetupC),
    .PULSE_CYCLES     (PulseC),
    .HOLD_CYCLES      (HoldC),
    .NIBBLE_GAP_CYCLES(GapC),
    .BYTE_WAIT_CYCLES (ByteC),
    .LONG_WAIT_CYCLES (LongC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       r;
    logic       nib;
    int         np;
    int         n;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transfer length straight from the timing rules.
  function automatic int model_n(input logic [7:0] d, input logic r, input logic nib);
    int n;
    n = SetupC + 1 + PulseC + HoldC;
    if (!nib) n += GapC + SetupC + PulseC + HoldC;
    n += (!r && !nib && d >= 8'd1 && d <= 8'd3) ? LongC : ByteC;
    return n;
  endfunction

  task automatic transfer(input logic [7:0] d, input logic r, input logic nib, input int exp_np,
                          input int exp_n, input bit noise, input string tag,
                          output int k_o, output int done_o);
    int t, k, np, off, done_off;
    bit prev_e, bad_rw, bad_ready, bad_stable;
    logic [3:0] prev_dat;
    logic prev_rs;
    int pst[2];
    int plen[2];
    logic [3:0] pdat[2];
    logic prs[2];
    t = 0;
    while (bus.ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("%s ready_before", tag), 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.data = d;
    bus.rs = r;
    bus.nibble_only = nib;
    @(posedge clk);
    #1;
    k = cyc;
    if (!noise) bus.start = 1'b0;
    bus.data = ~d;
    bus.rs = ~r;
    bus.nibble_only = ~nib;
    np = 0; done_off = -1; prev_e = 0; bad_rw = 0; bad_ready = 0; bad_stable = 0;
    prev_dat = bus.lcd_data; prev_rs = bus.lcd_rs;
    for (int i = 0; i < 2; i++) begin
      pst[i] = -1; plen[i] = 0; pdat[i] = '0; prs[i] = 1'b0;
    end
    for (int i = 0; i < exp_n + 30; i++) begin
      @(negedge clk);
      off = cyc - k;
      if (noise) begin
        bus.data = 8'($urandom);
        bus.rs = 1'($urandom);
        bus.nibble_only = 1'($urandom);
      end
      if ((bus.lcd_e === 1'b1) != prev_e &&
          (bus.lcd_data !== prev_dat || bus.lcd_rs !== prev_rs)) bad_stable = 1;
      if (bus.lcd_e === 1'b1 && !prev_e) begin
        if (np < 2) begin
          pst[np] = off; pdat[np] = bus.lcd_data; prs[np] = bus.lcd_rs;
        end
        np++;
      end
      if (bus.lcd_e === 1'b1 && np >= 1 && np <= 2) begin
        plen[np-1]++;
        if (bus.lcd_data !== pdat[np-1] || bus.lcd_rs !== prs[np-1]) bad_stable = 1;
      end
      prev_e = (bus.lcd_e === 1'b1);
      prev_dat = bus.lcd_data;
      prev_rs = bus.lcd_rs;
      if (bus.lcd_rw !== 1'b0) bad_rw = 1;
      if (bus.done === 1'b1) begin
        done_off = off;
        check($sformatf("%s ready_at_done", tag), 32'(bus.ready), 32'd1);
        break;
      end
      if (bus.ready !== 1'b0) bad_ready = 1;
    end
    check($sformatf("%s pulses", tag), np, exp_np);
    check($sformatf("%s done_offset", tag), done_off, exp_n);
    check($sformatf("%s hi_start", tag), pst[0], FirstOff);
    check($sformatf("%s hi_len", tag), plen[0], PulseC);
    check($sformatf("%s hi_data", tag), 32'(pdat[0]), 32'(d[7:4]));
    check($sformatf("%s hi_rs", tag), 32'(prs[0]), 32'(r));
    if (exp_np == 2) begin
      check($sformatf("%s lo_start", tag), pst[1], SecondOff);
      check($sformatf("%s lo_len", tag), plen[1], PulseC);
      check($sformatf("%s lo_data", tag), 32'(pdat[1]), 32'(d[3:0]));
      check($sformatf("%s lo_rs", tag), 32'(prs[1]), 32'(r));
    end
    check($sformatf("%s rw_zero", tag), 32'(bad_rw), 32'd0);
    check($sformatf("%s ready_low_busy", tag), 32'(bad_ready), 32'd0);
    check($sformatf("%s e_isolated", tag), 32'(bad_stable), 32'd0);
    k_o = k;
    done_o = done_off;
  endtask

  initial begin
    vec_t vecs[8];
    int k, dn, k2, dn2, start_k;
    logic [7:0] d;
    logic r, nib;
    bit seen_done, seen_e, not_ready;

    vecs[0] = '{d: 8'h48, r: 1'b1, nib: 1'b0, np: 2, n: FullN};
    vecs[1] = '{d: 8'h30, r: 1'b0, nib: 1'b1, np: 1, n: NibN};
    vecs[2] = '{d: 8'h01, r: 1'b0, nib: 1'b0, np: 2, n: LongN};
    vecs[3] = '{d: 8'h01, r: 1'b1, nib: 1'b0, np: 2, n: FullN};
    vecs[4] = '{d: 8'h02, r: 1'b0, nib: 1'b0, np: 2, n: LongN};
    vecs[5] = '{d: 8'h03, r: 1'b0, nib: 1'b1, np: 1, n: NibN};
    vecs[6] = '{d: 8'h04, r: 1'b0, nib: 1'b0, np: 2, n: FullN};
    vecs[7] = '{d: 8'h20, r: 1'b0, nib: 1'b1, np: 1, n: NibN};

    bus.start = 1'b0;
    bus.data = '0;
    bus.rs = 1'b0;
    bus.nibble_only = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset e", 32'(bus.lcd_e), 32'd0);
    check("reset rs", 32'(bus.lcd_rs), 32'd0);
    check("reset rw", 32'(bus.lcd_rw), 32'd0);
    check("reset data", 32'(bus.lcd_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      transfer(vecs[i].d, vecs[i].r, vecs[i].nib, vecs[i].np, vecs[i].n, 1'b0,
               $sformatf("vec%0d", i), k, dn);
    end

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(1, 3));
      r = 1'($urandom_range(0, 1));
      nib = 1'($urandom_range(0, 1));
      transfer(d, r, nib, nib ? 1 : 2, model_n(d, r, nib), 1'b0, $sformatf("rnd%0d", i), k, dn);
    end

    // Start held high with scrambled inputs; next byte must launch in the done cycle.
    transfer(8'h5A, 1'b1, 1'b0, 2, FullN, 1'b1, "noise", k, dn);
    transfer(8'hC3, 1'b0, 1'b0, 2, FullN, 1'b0, "b2b", k2, dn2);
    check("b2b start_edge", k2, k + dn + 1);

    // Reset while E is high abandons the byte without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.data = 8'h48;
    bus.rs = 1'b1;
    bus.nibble_only = 1'b0;
    @(posedge clk);
    #1;
    start_k = cyc;
    bus.start = 1'b0;
    while (cyc - start_k < 8) @(negedge clk);
    check("midrst e_before", 32'(bus.lcd_e), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst e", 32'(bus.lcd_e), 32'd0);
    check("midrst data", 32'(bus.lcd_data), 32'd0);
    check("midrst ready", 32'(bus.ready), 32'd1);
    check("midrst done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    seen_done = 0;
    seen_e = 0;
    repeat (FullN + 50) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1;
      if (bus.lcd_e === 1'b1) seen_e = 1;
    end
    check("midrst no_done", 32'(seen_done), 32'd0);
    check("midrst no_e", 32'(seen_e), 32'd0);
    transfer(8'h06, 1'b0, 1'b0, 2, FullN, 1'b0, "after_rst", k, dn);

    // Reset wins over a simultaneous start in IDLE.
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.data = 8'h48;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    seen_e = 0;
    not_ready = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.lcd_e === 1'b1) seen_e = 1;
      if (bus.ready !== 1'b1) not_ready = 1;
    end
    check("rst_start no_e", 32'(seen_e), 32'd0);
    check("rst_start stays_ready", 32'(not_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_writer.md
Name: lcd_nibble_writer

Overview:
Downstream execution stage for the LCD instructions that program memory issues. It accepts one 8-bit LCD byte (command or character) per handshake and drives the Spartan-3E character LCD in 4-bit mode. It sends the upper nibble first, then the lower nibble, and owns all HD44780 setup, enable-pulse, hold and post-write wait timing, so the CPU no longer needs NOP/SHL sequences per nibble. It also supports a single-nibble mode for the power-on init sequence (0x3, 0x3, 0x3, 0x2 writes).

Parameters:
SETUP_CYCLES, 2, RS/data valid before E rises (40 ns at 50 MHz); min 1
PULSE_CYCLES, 12, E high time (240 ns); min 1
HOLD_CYCLES, 1, RS/data held after E falls (20 ns); min 1
NIBBLE_GAP_CYCLES, 50, gap between upper and lower nibble (1 us); min 1
BYTE_WAIT_CYCLES, 2000, wait after a normal byte or single nibble (40 us); min 1
LONG_WAIT_CYCLES, 82000, wait after Clear Display / Return Home (1.64 ms); min 1

Ports:
Clock  input  1  system clock, 50 MHz
Reset  input  1  synchronous, active-high reset
iStart  input  1  request; sampled only when oReady=1
iData  input  8  byte to send; in nibble mode only iData[7:4] is sent
iRS  input  1  0 = command, 1 = data register
iNibbleOnly  input  1  1 = send iData[7:4] only
oReady  output  1  high only in IDLE; accepts iStart
oDone  output  1  one-cycle pulse when a transfer completes
oLCD_E  output  1  LCD enable
oLCD_RS  output  1  LCD register select
oLCD_RW  output  1  LCD read/write; constant 0
oLCD_Data  output  4  LCD DB[7:4] (SF_D[11:8])

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset state: IDLE. oReady=1, oDone=0, oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_Data=0, wait counter=0.
- Reset takes priority over everything, including mid-transfer. At the next edge oLCD_E=0 and the state is IDLE; an in-flight byte is abandoned and oDone is not pulsed.
- Start: at an edge where the state is IDLE and iStart=1:
  - iData, iRS and iNibbleOnly are latched; later input changes are ignored.
  - oReady drops at that edge.
  - iStart is ignored in any other state (no queueing).
- FSM states and dwell times:
  - IDLE: waits for iStart.
  - SETUP_HI: SETUP_CYCLES cycles.
  - PULSE_HI: PULSE_CYCLES cycles.
  - HOLD_HI: HOLD_CYCLES cycles.
  - GAP: NIBBLE_GAP_CYCLES cycles.
  - SETUP_LO, PULSE_LO, HOLD_LO: same durations as the _HI states.
  - WAIT: BYTE_WAIT_CYCLES or LONG_WAIT_CYCLES (see wait selection).
- Transitions:
  - HOLD_HI -> WAIT if the latched nibble flag is set, otherwise HOLD_HI -> GAP.
  - WAIT -> IDLE.
- Outputs by state:
  - oLCD_E=1 only in PULSE_HI and PULSE_LO.
  - oLCD_Data=latched[7:4] in SETUP_HI through GAP; latched[3:0] in SETUP_LO through HOLD_LO; 0 in WAIT and IDLE.
  - oLCD_RS=latched RS from SETUP_HI through HOLD_LO; 0 in WAIT and IDLE.
- All outputs are registered and glitch-free. E never changes in the same cycle as RS or data.
- Wait selection: LONG_WAIT_CYCLES when latched RS=0, nibble flag=0 and latched byte is 0x01, 0x02 or 0x03. Otherwise BYTE_WAIT_CYCLES.
- Completion: on the edge leaving WAIT, the state becomes IDLE and oDone=1 and oReady=1 for exactly that one cycle. If iStart=1 in that cycle, a new transfer starts (back-to-back allowed).
- Latency with defaults, start sampled at edge k (IDLE entered at edge k+N):
  - Full byte: N=2081. E high cycles k+3..k+14 and k+68..k+79.
  - Nibble-only: N=2016.
  - Long command: N=82081.
- Counter: a single down-counter, 20 bits wide. Every parameter must be ≤ 2^20−1; elaboration fails otherwise.

Test Plan:
- Reset, then iStart with iData=0x48 ('H'), iRS=1 -> E pulses 12 cycles at k+3 (Data=0x4, RS=1) and at k+68 (Data=0x8); oDone at k+2081; RW=0 throughout.
- iStart with iData=0x30, iNibbleOnly=1, iRS=0 -> exactly one E pulse with Data=0x3; oDone at k+2016.
- iStart with iData=0x01, iRS=0 -> two pulses (0x0 then 0x1); oDone at k+82081. Repeat with iRS=1 -> oDone at k+2081.
- iStart asserted continuously with iData changing every cycle -> only the latched value is sent; the next transfer starts in the oDone cycle; oReady=0 for the whole busy period.
- Reset asserted at k+8 (E high) -> at k+9 E=0, Data=0, oReady=1, oDone never pulses; a new 0x06 command then completes normally.
- Reset and iStart high together in IDLE -> no transfer starts; E stays 0.
